// File: rtl/i2c_seq_pkg.sv
// Shared encodings for the I2C transfer sequencer: engine opcodes, FSM states
// and completion error codes.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    OP_START   = 3'd0,
    OP_RESTART = 3'd1,
    OP_WRITE   = 3'd2,
    OP_READ    = 3'd3,
    OP_STOP    = 3'd4
  } cmd_op_e;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_START = 4'd1,
    S_DEVW  = 4'd2,
    S_REG   = 4'd3,
    S_WDAT  = 4'd4,
    S_RSTRT = 4'd5,
    S_DEVR  = 4'd6,
    S_RDAT  = 4'd7,
    S_STOP  = 4'd8,
    S_DONE  = 4'd9
  } seq_state_e;

  typedef enum logic {
    PH_ISSUE = 1'b0,
    PH_WAIT  = 1'b1
  } seq_phase_e;

  typedef enum logic [1:0] {
    ERR_OK   = 2'd0,
    ERR_ADDR = 2'd1,
    ERR_DATA = 2'd2,
    ERR_TMO  = 2'd3
  } seq_err_e;

endpackage

// File: rtl/i2c_seq_rr_arb.sv
// Two-way round-robin arbiter; last_gnt points at the most recent winner so the
// other requester wins the next contested grant.
module i2c_seq_rr_arb
  import i2c_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_gnt;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (advance && (|req)) begin
      last_gnt <= gnt[1];
    end
  end

endmodule

// File: rtl/i2c_xfer_sequencer.sv
// Expands arbitrated register read/write requests into I2C byte-engine commands.
// Optional per-response watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request; grants and latches it
// START | START condition
// DEVW  | device address, write direction
// REG   | register address byte
// WDAT  | write data byte
// RSTRT | repeated START
// DEVR  | device address, read direction
// RDAT  | single-byte read, master NACKs
// STOP  | STOP condition, always issued once a transfer starts
// DONE  | one-cycle completion pulse
module i2c_xfer_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_rw,
  input  logic [1:0][6:0] req_dev,
  input  logic [1:0][7:0] req_reg,
  input  logic [1:0][7:0] req_wdata,
  output logic            done_valid,
  output logic            done_id,
  output logic [7:0]      done_rdata,
  output logic [1:0]      done_err,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic [2:0]      cmd_op,
  output logic [7:0]      cmd_wdata,
  output logic            cmd_nack_rd,
  input  logic            rsp_valid,
  input  logic            rsp_nack,
  input  logic [7:0]      rsp_rdata,
  output logic            busy
);

  seq_state_e state_q, state_d;
  seq_phase_e phase_q, phase_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [1:0] req_ready_q, req_ready_d;
  logic       id_q, id_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] regaddr_q, regaddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  seq_err_e   err_q, err_d;
  logic [1:0] arb_gnt;
  logic       arb_advance;
  cmd_op_e    op_w;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
`endif

  i2c_seq_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (arb_advance),
    .gnt     (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_ISSUE;
      cmd_valid_q <= 1'b0;
      req_ready_q <= 2'b00;
      id_q        <= 1'b0;
      rw_q        <= 1'b0;
      dev_q       <= '0;
      regaddr_q   <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= ERR_OK;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cmd_valid_q <= cmd_valid_d;
      req_ready_q <= req_ready_d;
      id_q        <= id_d;
      rw_q        <= rw_d;
      dev_q       <= dev_d;
      regaddr_q   <= regaddr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cmd_valid_d = 1'b0;
    req_ready_d = 2'b00;
    id_d        = id_q;
    rw_d        = rw_q;
    dev_d       = dev_q;
    regaddr_d   = regaddr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    arb_advance = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          arb_advance = 1'b1;
          req_ready_d = arb_gnt;
          id_d        = arb_gnt[1];
          rw_d        = req_rw[arb_gnt[1]];
          dev_d       = req_dev[arb_gnt[1]];
          regaddr_d   = req_reg[arb_gnt[1]];
          wdata_d     = req_wdata[arb_gnt[1]];
          rdata_d     = '0;
          err_d       = ERR_OK;
          state_d     = S_START;
          phase_d     = PH_ISSUE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (phase_q == PH_ISSUE) begin
          if (cmd_valid_q && cmd_ready) begin
            phase_d = PH_WAIT;
`ifdef I2C_SEQ_TIMEOUT_EN
            tmo_d   = TMO_LOAD;
`endif
          end else begin
            cmd_valid_d = 1'b1;
          end
        end else if (rsp_valid) begin
          phase_d = PH_ISSUE;
          // A NACK on any byte skips straight to STOP so the bus is released.
          unique case (state_q)
            S_START: state_d = S_DEVW;
            S_DEVW: begin
              if (rsp_nack) begin
                err_d   = ERR_ADDR;
                state_d = S_STOP;
              end else begin
                state_d = S_REG;
              end
            end
            S_REG: begin
              if (rsp_nack) begin
                err_d   = ERR_DATA;
                state_d = S_STOP;
              end else begin
                state_d = rw_q ? S_RSTRT : S_WDAT;
              end
            end
            S_WDAT: begin
              if (rsp_nack) err_d = ERR_DATA;
              state_d = S_STOP;
            end
            S_RSTRT: state_d = S_DEVR;
            S_DEVR: begin
              if (rsp_nack) begin
                err_d   = ERR_ADDR;
                state_d = S_STOP;
              end else begin
                state_d = S_RDAT;
              end
            end
            S_RDAT: begin
              rdata_d = rsp_rdata;
              state_d = S_STOP;
            end
            S_STOP:  state_d = S_DONE;
            default: state_d = S_IDLE;
          endcase
        end
`ifdef I2C_SEQ_TIMEOUT_EN
        else if (tmo_q == '0) begin
          err_d   = ERR_TMO;
          phase_d = PH_ISSUE;
          state_d = (state_q == S_STOP) ? S_DONE : S_STOP;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
`endif
      end
    endcase
  end

  always_comb begin
    op_w      = OP_START;
    cmd_wdata = 8'h00;
    unique case (state_q)
      S_START: op_w = OP_START;
      S_DEVW: begin
        op_w      = OP_WRITE;
        cmd_wdata = {dev_q, 1'b0};
      end
      S_REG: begin
        op_w      = OP_WRITE;
        cmd_wdata = regaddr_q;
      end
      S_WDAT: begin
        op_w      = OP_WRITE;
        cmd_wdata = wdata_q;
      end
      S_RSTRT: op_w = OP_RESTART;
      S_DEVR: begin
        op_w      = OP_WRITE;
        cmd_wdata = {dev_q, 1'b1};
      end
      S_RDAT:  op_w = OP_READ;
      S_STOP:  op_w = OP_STOP;
      default: op_w = OP_START;
    endcase
  end

  assign cmd_op      = op_w;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_nack_rd = (state_q == S_RDAT);
  assign req_ready   = req_ready_q;
  assign busy        = (state_q != S_IDLE);

  // Completion fields are masked outside the pulse; read data only survives a clean transfer.
  assign done_valid = (state_q == S_DONE);
  assign done_id    = done_valid & id_q;
  assign done_err   = done_valid ? err_q : ERR_OK;
  assign done_rdata = (done_valid && (err_q == ERR_OK)) ? rdata_q : 8'h00;

endmodule
